wb_mprj_arbiter: RTL and testbench

Round-robin Wishbone arbiter that shares the single user-project (mprj) slave port between NUM_MASTERS requesters, e.g. the management core and a DMA/debug master. It sits between the masters and the mprj bus. A watchdog terminates any cycle that the slave never acknowledges, returning an error plus a 32'hDEADBEEF poison value so that a hung user project cannot stall the SoC.

---
 rtl/wb_mprj_arbiter_pkg.sv | 16 +
 rtl/wb_mprj_arbiter_if.sv | 38 +++
 rtl/wb_mprj_arbiter_rr_picker.sv | 28 ++
 rtl/wb_mprj_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_mprj_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_mprj_arbiter_pkg.sv
// rtl/wb_mprj_arbiter_pkg.sv - shared types and constants for the mprj Wishbone arbiter
package wb_arb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  localparam logic [WB_DW-1:0] WB_POISON_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_mprj_arbiter_if.sv
// rtl/wb_mprj_arbiter_if.sv - requester-side and mprj-side Wishbone signals of the arbiter
interface wb_mprj_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) ();

  logic [NUM_MASTERS-1:0]       m_cyc_i;
  logic [NUM_MASTERS-1:0]       m_stb_i;
  logic [NUM_MASTERS-1:0]       m_we_i;
  logic [WB_SW*NUM_MASTERS-1:0] m_sel_i;
  logic [WB_AW*NUM_MASTERS-1:0] m_adr_i;
  logic [WB_DW*NUM_MASTERS-1:0] m_dat_i;
  logic [NUM_MASTERS-1:0]       m_ack_o;
  logic [NUM_MASTERS-1:0]       m_err_o;
  logic [WB_DW*NUM_MASTERS-1:0] m_dat_o;

  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [WB_SW-1:0] s_sel_o;
  logic [WB_AW-1:0] s_adr_o;
  logic [WB_DW-1:0] s_dat_o;
  logic             s_ack_i;
  logic [WB_DW-1:0] s_dat_i;

  // The arbiter is the slave of the requesters and drives the mprj port.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

endinterface

// File: rtl/wb_mprj_arbiter_rr_picker.sv
// rtl/wb_mprj_arbiter_rr_picker.sv - round-robin pick of the first requester after the last grant
module rr_picker #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    // Search starts one past the last winner and wraps, so the last winner is tried last.
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(last_i) + i) % N);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_mprj_arbiter.sv
// rtl/wb_mprj_arbiter.sv - round-robin arbiter for the mprj Wishbone port with hung-slave watchdog
module wb_mprj_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  wb_mprj_arbiter_if.slave       bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   busy_o
);

  localparam int            PW      = $clog2(NUM_MASTERS);
  localparam int            CW      = 16;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;
  logic [PW-1:0]          gidx;
  logic                   g_cyc, g_stb, g_we;
  logic [WB_SW-1:0]       g_sel;
  logic [WB_AW-1:0]       g_adr;
  logic [WB_DW-1:0]       g_dat;

  assign req = bus.m_cyc_i & bus.m_stb_i;

  rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req_i   (req),
    .last_i  (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) gidx = PW'(k);
    end
  end

  always_comb begin
    g_cyc = bus.m_cyc_i[gidx];
    g_stb = bus.m_stb_i[gidx];
    g_we  = bus.m_we_i[gidx];
    g_sel = bus.m_sel_i[gidx*WB_SW +: WB_SW];
    g_adr = bus.m_adr_i[gidx*WB_AW +: WB_AW];
    g_dat = bus.m_dat_i[gidx*WB_DW +: WB_DW];
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_dat_o = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          state_d = BUSY;
        end
      end

      BUSY: begin
        bus.s_cyc_o = g_cyc;
        bus.s_stb_o = g_stb;
        bus.s_we_o  = g_we;
        bus.s_sel_o = g_sel;
        bus.s_adr_o = g_adr;
        bus.s_dat_o = g_dat;
        bus.m_ack_o[gidx]                 = bus.s_ack_i;
        bus.m_dat_o[gidx*WB_DW +: WB_DW] = bus.s_dat_i;
        // Ack is checked before the threshold so a late ack still completes normally.
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = gidx;
          cnt_d   = '0;
        end else if (bus.s_ack_i) begin
          cnt_d = '0;
        end else if (g_stb) begin
          if (cnt_q == TO_LAST) begin
            state_d = ERR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ERR: begin
        bus.m_err_o[gidx]                 = 1'b1;
        bus.m_dat_o[gidx*WB_DW +: WB_DW] = WB_POISON_DATA;
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = gidx;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!rstn_i) $onehot0(grant_q));
  a_ack_err_excl:  assert property (@(posedge clk_i) disable iff (!rstn_i) (bus.m_ack_o & bus.m_err_o) == '0);

endmodule

// File: tb/tb_wb_mprj_arbiter.sv
// tb/tb_wb_mprj_arbiter.sv - directed and randomized checks of wb_mprj_arbiter against a behavioural model
module tb_wb_mprj_arbiter;

  localparam int          NM     = 3;
  localparam int          TO     = 8;
  localparam logic [31:0] POISON = 32'hDEADBEEF;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [NM-1:0] grant_o;
  logic          busy_o;
  int            n_checks = 0;
  int            n_fail = 0;

  wb_mprj_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  wb_mprj_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .bus     (bus),
    .grant_o (grant_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [70:0] s_snap();
    return {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o, bus.s_adr_o, bus.s_dat_o};
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
    bus.m_sel_i = '0; bus.m_adr_i = '0; bus.m_dat_i = '0;
    bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
  endtask

  task automatic set_master(input int k, input logic cyc, input logic stb, input logic we,
                            input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    bus.m_cyc_i[k] = cyc; bus.m_stb_i[k] = stb; bus.m_we_i[k] = we;
    bus.m_sel_i[k*4 +: 4] = sel; bus.m_adr_i[k*32 +: 32] = adr; bus.m_dat_i[k*32 +: 32] = dat;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    idle_inputs();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    bus.m_cyc_i = '1; bus.m_stb_i = '1; bus.m_we_i = '1;
    bus.m_sel_i = '1; bus.m_adr_i = {3{$urandom}}; bus.m_dat_i = {3{$urandom}};
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'hA5A5_5A5A;
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({grant_o, busy_o} !== '0) begin n_fail++; $display("FAIL reset_grant_busy: got %b expected 0", {grant_o, busy_o}); end
    n_checks++;
    if (s_snap() !== '0) begin n_fail++; $display("FAIL reset_slave_side: got %h expected 0", s_snap()); end
    n_checks++;
    if ({bus.m_ack_o, bus.m_err_o, bus.m_dat_o} !== '0) begin
      n_fail++; $display("FAIL reset_master_side: got %h expected 0", {bus.m_ack_o, bus.m_err_o, bus.m_dat_o});
    end
    @(posedge clk_i);
    #1;
    idle_inputs();
    rstn_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({grant_o, busy_o} !== '0) begin n_fail++; $display("FAIL reset_release_idle: got %b expected 0", {grant_o, busy_o}); end
  endtask

  task automatic test_single_write();
    do_reset();
    set_master(0, 1, 1, 1, 4'hF, 32'h3000_0000, 32'h1234_5678);
    @(negedge clk_i);
    n_checks++;
    if ({bus.s_cyc_o, grant_o} !== 4'b0000) begin n_fail++; $display("FAIL write_latency: got %b expected 0000", {bus.s_cyc_o, grant_o}); end
    next_cycle();
    @(negedge clk_i);
    n_checks++;
    if (s_snap() !== {3'b111, 4'hF, 32'h3000_0000, 32'h1234_5678}) begin
      n_fail++; $display("FAIL write_passthru: got %h expected %h", s_snap(), {3'b111, 4'hF, 32'h3000_0000, 32'h1234_5678});
    end
    n_checks++;
    if ({grant_o, busy_o, bus.m_ack_o} !== {3'b001, 1'b1, 3'b000}) begin
      n_fail++; $display("FAIL write_grant: got %b expected 0011000", {grant_o, busy_o, bus.m_ack_o});
    end
    next_cycle();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h0BAD_F00D;
    @(negedge clk_i);
    n_checks++;
    if ({bus.m_ack_o, bus.m_err_o} !== 6'b001000) begin n_fail++; $display("FAIL write_ack: got %b expected 001000", {bus.m_ack_o, bus.m_err_o}); end
    next_cycle();
    bus.s_ack_i = 1'b0;
    set_master(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    n_checks++;
    if ({bus.m_ack_o, bus.s_cyc_o, grant_o} !== 7'b000_0_001) begin
      n_fail++; $display("FAIL write_release: got %b expected 0000001", {bus.m_ack_o, bus.s_cyc_o, grant_o});
    end
    next_cycle();
    @(negedge clk_i);
    n_checks++;
    if ({grant_o, busy_o} !== 4'b0000) begin n_fail++; $display("FAIL write_idle: got %b expected 0000", {grant_o, busy_o}); end
  endtask

  task automatic test_alternate();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      int            w;
      logic [NM-1:0] eg;
      w = r % 2;
      eg = '0;
      eg[w] = 1'b1;
      set_master(0, 1, 1, 0, 4'hF, 32'h3000_0010, 32'h0);
      set_master(1, 1, 1, 0, 4'hF, 32'h3000_0020, 32'h0);
      @(negedge clk_i);
      n_checks++;
      if ({grant_o, busy_o} !== 4'b0000) begin n_fail++; $display("FAIL alt_idle r%0d: got %b expected 0000", r, {grant_o, busy_o}); end
      next_cycle();
      bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h1000 + r;
      @(negedge clk_i);
      n_checks++;
      if ({grant_o, bus.m_ack_o} !== {eg, eg}) begin
        n_fail++; $display("FAIL alt_grant r%0d: got %b expected %b", r, {grant_o, bus.m_ack_o}, {eg, eg});
      end
      n_checks++;
      if (bus.s_adr_o !== (w == 0 ? 32'h3000_0010 : 32'h3000_0020)) begin
        n_fail++; $display("FAIL alt_adr r%0d: got %h expected master %0d address", r, bus.s_adr_o, w);
      end
      next_cycle();
      bus.s_ack_i = 1'b0;
      set_master(w, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      @(negedge clk_i);
      n_checks++;
      if ({grant_o, bus.s_cyc_o} !== {eg, 1'b0}) begin
        n_fail++; $display("FAIL alt_drop r%0d: got %b expected %b", r, {grant_o, bus.s_cyc_o}, {eg, 1'b0});
      end
      next_cycle();
    end
  endtask

  task automatic test_burst();
    logic [NM*32-1:0] ed;
    do_reset();
    set_master(1, 1, 1, 0, 4'hF, 32'h3000_0100, 32'h0);
    next_cycle();
    set_master(0, 1, 1, 1, 4'h3, 32'h3000_0200, 32'hCAFE_0000);
    for (int b = 0; b < 4; b++) begin
      logic [31:0] rd;
      rd = $urandom;
      bus.s_ack_i = 1'b1; bus.s_dat_i = rd;
      bus.m_adr_i[32 +: 32] = 32'h3000_0100 + 32'(4 * b);
      ed = '0;
      ed[32 +: 32] = rd;
      @(negedge clk_i);
      n_checks++;
      if ({grant_o, bus.m_ack_o} !== 6'b010_010) begin n_fail++; $display("FAIL burst_ack b%0d: got %b expected 010010", b, {grant_o, bus.m_ack_o}); end
      n_checks++;
      if (bus.m_dat_o !== ed) begin n_fail++; $display("FAIL burst_data b%0d: got %h expected %h", b, bus.m_dat_o, ed); end
      n_checks++;
      if (bus.s_adr_o !== 32'h3000_0100 + 32'(4 * b)) begin n_fail++; $display("FAIL burst_adr b%0d: got %h", b, bus.s_adr_o); end
      next_cycle();
    end
    bus.s_ack_i = 1'b0;
    set_master(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    n_checks++;
    if ({grant_o, bus.s_cyc_o} !== 4'b010_0) begin n_fail++; $display("FAIL burst_end: got %b expected 0100", {grant_o, bus.s_cyc_o}); end
    next_cycle();
    @(negedge clk_i);
    n_checks++;
    if ({grant_o, busy_o} !== 4'b0000) begin n_fail++; $display("FAIL burst_gap: got %b expected 0000", {grant_o, busy_o}); end
    next_cycle();
    @(negedge clk_i);
    n_checks++;
    if ({grant_o, bus.s_cyc_o, bus.s_we_o, bus.s_sel_o, bus.s_adr_o} !== {3'b001, 2'b11, 4'h3, 32'h3000_0200}) begin
      n_fail++; $display("FAIL burst_next_grant: got %b %h expected 001 11 3 30000200", grant_o, {bus.s_cyc_o, bus.s_we_o, bus.s_sel_o, bus.s_adr_o});
    end
    next_cycle();
    set_master(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_timeout();
    logic [NM*32-1:0] ed;
    do_reset();
    set_master(2, 1, 1, 0, 4'hF, 32'h3000_0300, 32'h0);
    next_cycle();
    for (int i = 0; i < TO; i++) begin
      @(negedge clk_i);
      n_checks++;
      if ({bus.s_cyc_o, bus.s_stb_o, bus.m_err_o, grant_o} !== {2'b11, 3'b000, 3'b100}) begin
        n_fail++; $display("FAIL timeout_stall c%0d: got %b expected 11000100", i, {bus.s_cyc_o, bus.s_stb_o, bus.m_err_o, grant_o});
      end
      next_cycle();
    end
    ed = '0;
    ed[64 +: 32] = POISON;
    @(negedge clk_i);
    n_checks++;
    if ({bus.m_err_o, bus.m_ack_o, busy_o} !== 7'b100_000_1) begin
      n_fail++; $display("FAIL timeout_err: got %b expected 1000001", {bus.m_err_o, bus.m_ack_o, busy_o});
    end
    n_checks++;
    if (bus.m_dat_o !== ed) begin n_fail++; $display("FAIL timeout_poison: got %h expected %h", bus.m_dat_o, ed); end
    n_checks++;
    if ({bus.s_cyc_o, bus.s_stb_o} !== 2'b00) begin n_fail++; $display("FAIL timeout_cyc_low: got %b expected 00", {bus.s_cyc_o, bus.s_stb_o}); end
    next_cycle();
    set_master(2, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    n_checks++;
    if ({bus.m_err_o, busy_o} !== 4'b0000) begin n_fail++; $display("FAIL timeout_err_pulse: got %b expected 0000", {bus.m_err_o, busy_o}); end
    next_cycle();
    set_master(2, 1, 1, 0, 4'hF, 32'h3000_0304, 32'h0);
    next_cycle();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h55AA_0001;
    @(negedge clk_i);
    n_checks++;
    if ({grant_o, bus.m_ack_o, bus.m_err_o, bus.m_dat_o[64 +: 32]} !== {9'b100_100_000, 32'h55AA_0001}) begin
      n_fail++; $display("FAIL timeout_recover: got %b %h", {grant_o, bus.m_ack_o, bus.m_err_o}, bus.m_dat_o[64 +: 32]);
    end
    next_cycle();
    bus.s_ack_i = 1'b0;
    set_master(2, 0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_ack_at_threshold();
    do_reset();
    set_master(0, 1, 1, 0, 4'hF, 32'h3000_0400, 32'h0);
    next_cycle();
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk_i);
      n_checks++;
      if ({bus.m_ack_o, bus.m_err_o} !== 6'b0) begin n_fail++; $display("FAIL thr_stall c%0d: got %b expected 000000", i, {bus.m_ack_o, bus.m_err_o}); end
      next_cycle();
    end
    bus.s_ack_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({bus.m_ack_o, bus.m_err_o} !== 6'b001_000) begin n_fail++; $display("FAIL thr_ack_wins: got %b expected 001000", {bus.m_ack_o, bus.m_err_o}); end
    next_cycle();
    bus.s_ack_i = 1'b0;
    set_master(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    n_checks++;
    if ({bus.m_err_o, busy_o} !== 4'b000_1) begin n_fail++; $display("FAIL thr_no_err: got %b expected 0001", {bus.m_err_o, busy_o}); end
    next_cycle();
    @(negedge clk_i);
    n_checks++;
    if ({bus.m_err_o, busy_o} !== 4'b0000) begin n_fail++; $display("FAIL thr_idle: got %b expected 0000", {bus.m_err_o, busy_o}); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_master(1, 1, 1, 1, 4'hF, 32'h3000_0500, 32'h7777_0000);
    next_cycle();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h1357_9BDF;
    @(negedge clk_i);
    n_checks++;
    if ({grant_o, bus.m_ack_o, bus.s_cyc_o} !== 7'b010_010_1) begin
      n_fail++; $display("FAIL areset_pre: got %b expected 0100101", {grant_o, bus.m_ack_o, bus.s_cyc_o});
    end
    #2;
    rstn_i = 1'b0;
    #1;
    n_checks++;
    if ({grant_o, busy_o, bus.m_ack_o, bus.m_err_o, bus.m_dat_o, s_snap()} !== '0) begin
      n_fail++; $display("FAIL areset_immediate: got grant %b busy %b ack %b slave %h", grant_o, busy_o, bus.m_ack_o, s_snap());
    end
    set_master(0, 1, 1, 0, 4'hF, 32'h3000_0600, 32'h0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    next_cycle();
    @(negedge clk_i);
    n_checks++;
    if ({grant_o, bus.s_adr_o} !== {3'b001, 32'h3000_0600}) begin
      n_fail++; $display("FAIL areset_first_win: got %b %h expected 001 30000600", grant_o, bus.s_adr_o);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    int               owner;
    int               last;
    int               stall;
    bit               in_err;
    bit               hung;
    logic [NM-1:0]    e_grant, e_ack, e_err;
    logic             e_busy;
    logic [70:0]      e_s;
    logic [NM*32-1:0] e_dat;
    do_reset();
    owner = -1; last = NM - 1; stall = 0; in_err = 0; hung = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) hung = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < NM; k++) begin
        if (bus.m_cyc_i[k]) begin
          if ($urandom_range(0, hung ? 31 : 7) == 0) bus.m_cyc_i[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          bus.m_cyc_i[k] = 1'b1;
        end
        bus.m_stb_i[k] = bus.m_cyc_i[k] ? (hung || $urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
        bus.m_we_i[k] = $urandom_range(0, 1) == 1;
        bus.m_sel_i[k*4 +: 4] = 4'($urandom);
        bus.m_adr_i[k*32 +: 32] = $urandom;
        bus.m_dat_i[k*32 +: 32] = $urandom;
      end
      bus.s_ack_i = !hung && ($urandom_range(0, 2) == 0);
      bus.s_dat_i = $urandom;
      @(negedge clk_i);
      e_grant = '0; e_busy = 1'b0; e_s = '0; e_ack = '0; e_err = '0; e_dat = '0;
      if (owner >= 0) begin
        e_grant[owner] = 1'b1;
        e_busy = 1'b1;
        if (in_err) begin
          e_err[owner] = 1'b1;
          e_dat[owner*32 +: 32] = POISON;
        end else begin
          e_s = {bus.m_cyc_i[owner], bus.m_stb_i[owner], bus.m_we_i[owner], bus.m_sel_i[owner*4 +: 4],
                 bus.m_adr_i[owner*32 +: 32], bus.m_dat_i[owner*32 +: 32]};
          e_ack[owner] = bus.s_ack_i;
          e_dat[owner*32 +: 32] = bus.s_dat_i;
        end
      end
      n_checks++;
      if ({grant_o, busy_o} !== {e_grant, e_busy}) begin
        n_fail++; $display("FAIL rand_grant c%0d: got %b expected %b", c, {grant_o, busy_o}, {e_grant, e_busy});
      end
      n_checks++;
      if (s_snap() !== e_s) begin n_fail++; $display("FAIL rand_slave c%0d: got %h expected %h", c, s_snap(), e_s); end
      n_checks++;
      if ({bus.m_ack_o, bus.m_err_o} !== {e_ack, e_err}) begin
        n_fail++; $display("FAIL rand_ack_err c%0d: got %b expected %b", c, {bus.m_ack_o, bus.m_err_o}, {e_ack, e_err});
      end
      n_checks++;
      if (bus.m_dat_o !== e_dat) begin n_fail++; $display("FAIL rand_rdata c%0d: got %h expected %h", c, bus.m_dat_o, e_dat); end
      if (in_err) begin
        in_err = 0; last = owner; owner = -1; stall = 0;
      end else if (owner >= 0) begin
        if (!bus.m_cyc_i[owner]) begin
          last = owner; owner = -1; stall = 0;
        end else if (bus.s_ack_i) begin
          stall = 0;
        end else if (bus.m_stb_i[owner]) begin
          stall++;
          if (stall == TO) begin in_err = 1; stall = 0; end
        end
      end else begin
        for (int j = 1; j <= NM; j++) begin
          int cand;
          cand = (last + j) % NM;
          if (owner < 0 && bus.m_cyc_i[cand] && bus.m_stb_i[cand]) owner = cand;
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_alternate();
    test_burst();
    test_timeout();
    test_ack_at_threshold();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "time limit");
  end

endmodule
